// File: rtl/float_pkg.sv
// Shared constants and types for the binary32 post-multiply normalize/round stage.
package float_pkg;

  localparam int BIAS      = 127;
  localparam int EXP_MAX   = 2 * BIAS + 1;
  localparam int FRAC_W    = 23;
  localparam int EXP_W     = 8;
  localparam int WORD_W    = 1 + EXP_W + FRAC_W;
  localparam int EXP_INT_W = 11;

  localparam logic signed [EXP_INT_W-1:0] EXP_TOP  = EXP_INT_W'(EXP_MAX);
  localparam logic signed [EXP_INT_W-1:0] EXP_ZERO = '0;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

endpackage

// File: rtl/float_round_rne.sv
// Round-to-nearest-even on a normalized fraction; a fraction carry-out bumps the exponent.
module float_round_rne
  import float_pkg::*;
(
  input  logic [FRAC_W-1:0]           frac_in,
  input  logic                        guard,
  input  logic                        sticky,
  input  logic signed [EXP_INT_W-1:0] exp_in,
  output logic [FRAC_W-1:0]           frac_out,
  output logic signed [EXP_INT_W-1:0] exp_out,
  output logic                        carry,
  output logic                        inexact
);

  logic          round_up;
  logic [FRAC_W:0] sum;

  assign round_up = guard & (sticky | frac_in[0]);
  assign sum      = {1'b0, frac_in} + {{FRAC_W{1'b0}}, round_up};
  assign carry    = sum[FRAC_W];
  // On carry the hidden bit moves up one place, so the stored fraction is all zeros.
  assign frac_out = sum[FRAC_W-1:0];
  assign exp_out  = exp_in + {{(EXP_INT_W-1){1'b0}}, carry};
  assign inexact  = guard | sticky;

endmodule

// File: rtl/float_normalize_round.sv
// Two-stage normalize / round-to-nearest-even / pack for the FP multiplier result path.
module float_normalize_round
  import float_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [9:0]        in_exp,
  input  logic [47:0]       in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_inexact
);

  logic advance;

  logic [FRAC_W-1:0]           n_frac;
  logic                        n_guard, n_sticky, n_zero;
  logic signed [EXP_INT_W-1:0] n_exp;

  logic                        s1_valid, s1_sign, s1_zero, s1_nonzero;
  logic [FRAC_W-1:0]           s1_frac;
  logic                        s1_guard, s1_sticky;
  logic signed [EXP_INT_W-1:0] s1_exp;

  logic [FRAC_W-1:0]           r_frac;
  logic signed [EXP_INT_W-1:0] r_exp;
  logic                        round_carry_unused, r_inexact;

  logic [WORD_W-1:0] p_result;
  flags_t            p_flags;

  // Single global stall: both stages move only when the output slot frees.
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    n_frac   = '0;
    n_guard  = 1'b0;
    n_sticky = 1'b0;
    n_zero   = 1'b0;
    n_exp    = {in_exp[9], in_exp};
    if (in_product[47]) begin
      n_frac   = in_product[46:24];
      n_guard  = in_product[23];
      n_sticky = |in_product[22:0];
      n_exp    = {in_exp[9], in_exp} + 11'd1;
    end else if (in_product[46]) begin
      n_frac   = in_product[45:23];
      n_guard  = in_product[22];
      n_sticky = |in_product[21:0];
    end else begin
      n_zero   = 1'b1;
    end
  end

  float_round_rne u_round (
    .frac_in  (s1_frac),
    .guard    (s1_guard),
    .sticky   (s1_sticky),
    .exp_in   (s1_exp),
    .frac_out (r_frac),
    .exp_out  (r_exp),
    .carry    (round_carry_unused),
    .inexact  (r_inexact)
  );

  always_comb begin
    p_result = {s1_sign, r_exp[EXP_W-1:0], r_frac};
    p_flags  = '{overflow: 1'b0, underflow: 1'b0, inexact: r_inexact};
    if (s1_zero) begin
      p_result = {s1_sign, {(WORD_W-1){1'b0}}};
      p_flags  = '{overflow: 1'b0, underflow: s1_nonzero, inexact: s1_nonzero};
    end else if (r_exp >= EXP_TOP) begin
      p_result = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      p_flags  = '{overflow: 1'b1, underflow: 1'b0, inexact: 1'b1};
    end else if (r_exp <= EXP_ZERO) begin
      p_result = {s1_sign, {(WORD_W-1){1'b0}}};
      p_flags  = '{overflow: 1'b0, underflow: 1'b1, inexact: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_sign       <= 1'b0;
      s1_zero       <= 1'b0;
      s1_nonzero    <= 1'b0;
      s1_frac       <= '0;
      s1_guard      <= 1'b0;
      s1_sticky     <= 1'b0;
      s1_exp        <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_sign    <= in_sign;
        s1_zero    <= n_zero;
        s1_nonzero <= |in_product[45:0];
        s1_frac    <= n_frac;
        s1_guard   <= n_guard;
        s1_sticky  <= n_sticky;
        s1_exp     <= n_exp;
      end
      if (s1_valid) begin
        out_result    <= p_result;
        out_overflow  <= p_flags.overflow;
        out_underflow <= p_flags.underflow;
        out_inexact   <= p_flags.inexact;
      end
    end
  end

endmodule

// File: tb/tb_float_normalize_round.sv
// Scoreboard bench for float_normalize_round: directed vectors, stall and mid-stream reset.
module tb_float_normalize_round;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_product = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_overflow, out_underflow, out_inexact;

  int checks = 0;
  int failures = 0;
  int delivered = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  float_normalize_round dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_product    (in_product),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens on the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=none", out_result);
      end else begin
        mon_e = sb.pop_front();
        check("result", {32'h0, out_result}, {32'h0, mon_e.result});
        check("flags {ovf,unf,inx}", {61'h0, out_overflow, out_underflow, out_inexact},
              {61'h0, mon_e.flags});
        delivered++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic sign, input logic [9:0] e, input logic [47:0] p,
                      input logic [31:0] res, input logic [2:0] flg);
    int w;
    in_valid   = 1'b1;
    in_sign    = sign;
    in_exp     = e;
    in_product = p;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept_within_50");
    end else begin
      sb.push_back('{result: res, flags: flg});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    int w;
    int base;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {63'h0, out_valid}, 64'd0);
    check("reset_in_ready", {63'h0, in_ready}, 64'd1);
    check("reset_result", {32'h0, out_result}, 64'd0);
    check("reset_flags", {61'h0, out_overflow, out_underflow, out_inexact}, 64'd0);
    @(posedge clk);
    #1;

    // 1.5*1.5 with latency observation
    send(1'b0, 10'd127, 48'h9000_0000_0000, 32'h4010_0000, 3'b000);
    @(negedge clk);
    check("latency_n", {63'h0, out_valid}, 64'd0);
    @(negedge clk);
    check("latency_n1", {63'h0, out_valid}, 64'd1);
    @(posedge clk);
    #1;

    send(1'b0, 10'd127,   48'h4000_0000_0000, 32'h3F80_0000, 3'b000);
    send(1'b0, 10'd127,   48'h4000_0040_0000, 32'h3F80_0000, 3'b001);
    send(1'b0, 10'd127,   48'h4000_00C0_0000, 32'h3F80_0002, 3'b001);
    send(1'b0, 10'd127,   48'h7FFF_FFC0_0000, 32'h4000_0000, 3'b001);
    send(1'b1, 10'd254,   48'h8000_0000_0000, 32'hFF80_0000, 3'b101);
    send(1'b0, 10'd0,     48'h4000_0000_0000, 32'h0000_0000, 3'b011);
    send(1'b1, 10'd127,   48'h0000_0000_0000, 32'h8000_0000, 3'b000);
    send(1'b0, 10'd127,   48'h0000_0000_0001, 32'h0000_0000, 3'b011);
    send(1'b0, 10'd253,   48'h8000_0000_0000, 32'h7F00_0000, 3'b000);
    send(1'b0, 10'd1,     48'h4000_0000_0000, 32'h0080_0000, 3'b000);
    send(1'b1, 10'h3FD,   48'h8000_0000_0000, 32'h8000_0000, 3'b011);
    send(1'b0, 10'd127,   48'hC000_0080_0000, 32'h4040_0000, 3'b001);
    send(1'b0, 10'd511,   48'h8000_0000_0000, 32'h7F80_0000, 3'b101);
    drain();

    // Back-pressure: four back-to-back inputs against a 3-cycle output stall
    base = delivered;
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 3'b000);
        send(1'b0, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 3'b001);
        send(1'b0, 10'd253, 48'h8000_0000_0000, 32'h7F00_0000, 3'b000);
        send(1'b0, 10'd1,   48'h4000_0000_0000, 32'h0080_0000, 3'b000);
      end
      begin
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        check("stall_out_valid", {63'h0, out_valid}, 64'd1);
        held = out_result;
        for (int i = 0; i < 3; i++) begin
          check("stall_in_ready", {63'h0, in_ready}, 64'd0);
          if (i > 0) check("stall_hold", {32'h0, out_result}, {32'h0, held});
          if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_delivered", 64'(delivered - base), 64'd4);

    // Reset with a result in flight: it must never appear
    send(1'b0, 10'd127, 48'h9000_0000_0000, 32'h4010_0000, 3'b000);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_out_valid", {63'h0, out_valid}, 64'd0);
    end
    check("post_reset_in_ready", {63'h0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    send(1'b1, 10'd127, 48'h4000_0000_0000, 32'hBF80_0000, 3'b000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
